tenyr_exec_unit: RTL and testbench

//  Parametrised next-generation execute unit for the tenyr core. Computes rhs = (X op Y) + A for
//  all 16 opcodes with a valid/ready handshake on both sides, replacing the fixed one-cycle,

---
 rtl/tenyr_pkg.sv | 36 +++
 rtl/tenyr_mul_pipe.sv | 64 ++++++
 rtl/tenyr_exec_unit.sv | 139 +++++++++++++
 tb/tb_tenyr_exec_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tenyr_pkg.sv
// Shared opcode encodings, FSM states and opcode classification helpers
// for the tenyr execute unit.
package tenyr_pkg;

  localparam logic [3:0] OP_OR   = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_RSV4 = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_LT   = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;
  localparam logic [3:0] OP_GT   = 4'h8;
  localparam logic [3:0] OP_ANDN = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_XNOR = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_NEQ  = 4'hE;
  localparam logic [3:0] OP_RSVF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSV4) || (op == OP_RSVF);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/tenyr_mul_pipe.sv
// Registered multiplier: operands enter a MUL_STAGES-1 deep delay chain on
// load, the chain advances while the FSM sits in MUL, and the final
// product plus addend is captured in prod_q.
module tenyr_mul_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0] prod_q;

  assign prod_o = prod_q;

  if (MUL_STAGES == 1) begin : g_direct
    logic unused_adv_s;
    assign unused_adv_s = adv_i;

    // Single-cycle multiply: product registered directly on accept.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prod_q <= '0;
      end else if (load_i) begin
        prod_q <= x_i * y_i + a_i;
      end
    end
  end else begin : g_chain
    localparam int DEPTH = MUL_STAGES - 1;
    logic [WIDTH-1:0] x_q [DEPTH];
    logic [WIDTH-1:0] y_q [DEPTH];
    logic [WIDTH-1:0] a_q [DEPTH];

    // Operand delay chain; the product register samples the chain tail.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          x_q[i] <= '0;
          y_q[i] <= '0;
          a_q[i] <= '0;
        end
        prod_q <= '0;
      end else if (load_i) begin
        x_q[0] <= x_i;
        y_q[0] <= y_i;
        a_q[0] <= a_i;
      end else if (adv_i) begin
        for (int i = 1; i < DEPTH; i++) begin
          x_q[i] <= x_q[i-1];
          y_q[i] <= y_q[i-1];
          a_q[i] <= a_q[i-1];
        end
        prod_q <= x_q[DEPTH-1] * y_q[DEPTH-1] + a_q[DEPTH-1];
      end
    end
  end

endmodule

// File: rtl/tenyr_exec_unit.sv
// tenyr execute unit: rhs = (X op Y) + A with valid/ready on both sides.
// Non-multiply ops register in one cycle; multiply goes through
// tenyr_mul_pipe and blocks input until its result is delivered.
module tenyr_exec_unit
  import tenyr_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rhs,
  output logic             out_illegal
);

  localparam int CNT_W = $clog2(MUL_STAGES + 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_s, accept_s;
  logic [WIDTH-1:0] op_res_s, rhs_s, mul_prod_s, alu_q;
  logic             illegal_q, mul_sel_q;
  logic             lt_s, gt_s, eq_s;

  assign lt_s = $signed(in_x) < $signed(in_y);
  assign gt_s = $signed(in_x) > $signed(in_y);
  assign eq_s = (in_x == in_y);

  // Combinational op mux; compares expand to all-ones or zero.
  always_comb begin
    op_res_s = '0;
    case (in_op)
      OP_OR:   op_res_s = in_x | in_y;
      OP_AND:  op_res_s = in_x & in_y;
      OP_ADD:  op_res_s = in_x + in_y;
      OP_SHL:  op_res_s = (in_y >= SHIFT_LIM) ? '0 : (in_x << in_y);
      OP_LT:   op_res_s = {WIDTH{lt_s}};
      OP_EQ:   op_res_s = {WIDTH{eq_s}};
      OP_GT:   op_res_s = {WIDTH{gt_s}};
      OP_ANDN: op_res_s = in_x & ~in_y;
      OP_XOR:  op_res_s = in_x ^ in_y;
      OP_SUB:  op_res_s = in_x - in_y;
      OP_XNOR: op_res_s = in_x ^ ~in_y;
      OP_SHR:  op_res_s = (in_y >= SHIFT_LIM) ? '0 : (in_x >> in_y);
      OP_NEQ:  op_res_s = {WIDTH{~eq_s}};
      default: op_res_s = '0;
    endcase
  end

  assign rhs_s = op_res_s + in_a;

  // FSM next state, multiply countdown and input-side ready.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_s = 1'b1;
      ST_MUL:  in_ready_s = 1'b0;
      ST_HOLD: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
    if (state_q == ST_MUL) begin
      // Leave MUL on the cycle the countdown reaches zero.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_MUL;
      end
    end else if (accept_s) begin
      if (is_mul(in_op) && (MUL_STAGES > 1)) begin
        state_d = ST_MUL;
        cnt_d   = CNT_W'(MUL_STAGES - 1);
      end else begin
        state_d = ST_HOLD;
      end
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_IDLE;
    end else begin
      // Unknown encodings fall back to IDLE.
      state_d = (state_q == ST_HOLD) ? ST_HOLD : ST_IDLE;
    end
  end

  // State and countdown registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result capture on accept; held untouched until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q     <= '0;
      illegal_q <= 1'b0;
      mul_sel_q <= 1'b0;
    end else if (accept_s) begin
      alu_q     <= rhs_s;
      illegal_q <= is_reserved(in_op);
      mul_sel_q <= is_mul(in_op);
    end
  end

  tenyr_mul_pipe #(
    .WIDTH      (WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (accept_s && is_mul(in_op)),
    .adv_i   (state_q == ST_MUL),
    .x_i     (in_x),
    .y_i     (in_y),
    .a_i     (in_a),
    .prod_o  (mul_prod_s)
  );

  assign in_ready    = in_ready_s;
  assign out_valid   = (state_q == ST_HOLD);
  assign out_rhs     = mul_sel_q ? mul_prod_s : alu_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_tenyr_exec_unit.sv
// Bench for tenyr_exec_unit (WIDTH=32, MUL_STAGES=3): directed vectors,
// a spec-level result model with an expected-result queue, and literal
// checks on the delivered-result log.
module tb_tenyr_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [31:0] in_x = 32'h0, in_y = 32'h0, in_a = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rhs;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int del_cnt = 0;

  logic [32:0] exp_q [$];
  logic [31:0] log_rhs [$];
  logic        log_ill [$];
  int          log_cyc [$];

  tenyr_exec_unit #(.WIDTH(32), .MUL_STAGES(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_a        (in_a),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rhs     (out_rhs),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result as the opcode table defines it: {illegal, rhs}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] a);
    int     sx, sy;
    longint p;
    logic [31:0] r;
    logic        ill;
    sx = x; sy = y; ill = 1'b0; r = 32'h0;
    case (op)
      4'h0: r = x | y;
      4'h1: r = x & y;
      4'h2: r = x + y;
      4'h3: begin p = longint'(sx) * longint'(sy); r = p[31:0]; end
      4'h5: r = (y >= 32'd32) ? 32'h0 : 32'(longint'(x) * (longint'(1) << y[4:0]));
      4'h6: r = (sx < sy) ? 32'hFFFF_FFFF : 32'h0;
      4'h7: r = (sx == sy) ? 32'hFFFF_FFFF : 32'h0;
      4'h8: r = (sx > sy) ? 32'hFFFF_FFFF : 32'h0;
      4'h9: r = x & ~y;
      4'hA: r = x ^ y;
      4'hB: r = x - y;
      4'hC: r = ~(x ^ y);
      4'hD: r = (y >= 32'd32) ? 32'h0 : 32'(longint'(x) / (longint'(1) << y[4:0]));
      4'hE: r = (sx != sy) ? 32'hFFFF_FFFF : 32'h0;
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
    return {ill, r + a};
  endfunction

  // Compare process: every cycle out_valid is high the outputs must match
  // the oldest accepted bundle; deliveries pop it, accepts push a new one.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        chk("result_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("model_rhs", out_rhs, exp_q[0][31:0]);
          chk("model_illegal", 32'(out_illegal), 32'(exp_q[0][32]));
        end
        if (out_ready) begin
          log_rhs.push_back(out_rhs);
          log_ill.push_back(out_illegal);
          log_cyc.push_back(cyc);
          del_cnt++;
          if (exp_q.size() > 0) exp_q.pop_front();
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_x, in_y, in_a));
        acc_cnt++;
      end
    end
  end

  // Present a bundle and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] a, output int waited);
    waited = 0;
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_a = a;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept op=%h", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, lb;
    logic [31:0] sx [2];
    logic [31:0] sy [2];
    sx[0] = 32'hF0F0_1234; sy[0] = 32'h0000_0004;
    sx[1] = 32'hFFFF_FFF6; sy[1] = 32'hFFFF_FFF6;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_rhs", out_rhs, 32'h0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back add
    out_ready = 1'b1;
    lb = log_rhs.size();
    send(4'h2, 32'd3, 32'd4, 32'd1, w);
    send(4'h2, 32'd5, 32'd5, 32'd0, w);
    chk("add_no_stall", 32'(w), 32'd0);
    settle();
    chk("add_count", 32'(log_rhs.size() - lb), 32'd2);
    if (log_rhs.size() >= lb + 2) begin
      chk("add_first", log_rhs[lb], 32'd8);
      chk("add_second", log_rhs[lb+1], 32'd10);
      chk("add_consecutive", 32'(log_cyc[lb+1] - log_cyc[lb]), 32'd1);
    end

    // Multiply latency with MUL_STAGES=3
    out_ready = 1'b0;
    lb = log_rhs.size();
    send(4'h3, 32'hFFFF_FFFE, 32'd7, 32'd100, w);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid", 32'(out_valid), 32'(k == 3));
      if (k == 3) chk("mul_rhs", out_rhs, 32'd86);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    settle();
    chk("mul_delivered_once", 32'(log_rhs.size() - lb), 32'd1);

    // Backpressure with a waiting bundle
    out_ready = 1'b0;
    lb = log_rhs.size();
    send(4'h2, 32'h0000_1000, 32'h0000_0234, 32'h0, w);
    in_valid = 1'b1; in_op = 4'h0; in_x = 32'h5; in_y = 32'h50; in_a = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rhs", out_rhs, 32'h1234);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    settle();
    chk("bp_count", 32'(log_rhs.size() - lb), 32'd2);
    if (log_rhs.size() >= lb + 2) begin
      chk("bp_first", log_rhs[lb], 32'h1234);
      chk("bp_second", log_rhs[lb+1], 32'h55);
    end

    // Compare / shift edges
    lb = log_rhs.size();
    send(4'h6, 32'hFFFF_FFFF, 32'd0, 32'd0, w);
    send(4'h5, 32'd1, 32'd32, 32'd5, w);
    send(4'hD, 32'h8000_0000, 32'd31, 32'd0, w);
    settle();
    chk("edge_count", 32'(log_rhs.size() - lb), 32'd3);
    if (log_rhs.size() >= lb + 3) begin
      chk("lt_neg", log_rhs[lb], 32'hFFFF_FFFF);
      chk("shl_wide", log_rhs[lb+1], 32'd5);
      chk("shr_msb", log_rhs[lb+2], 32'd1);
    end

    // Reserved opcode then a legal one
    lb = log_rhs.size();
    send(4'hF, 32'd9, 32'd9, 32'h42, w);
    send(4'h0, 32'd1, 32'd2, 32'd0, w);
    settle();
    chk("rsv_count", 32'(log_rhs.size() - lb), 32'd2);
    if (log_rhs.size() >= lb + 2) begin
      chk("rsv_rhs", log_rhs[lb], 32'h42);
      chk("rsv_illegal", 32'(log_ill[lb]), 32'd1);
      chk("or_rhs", log_rhs[lb+1], 32'd3);
      chk("or_illegal", 32'(log_ill[lb+1]), 32'd0);
    end

    // Sweep of every opcode against the model
    for (int s = 0; s < 2; s++) begin
      for (int op = 0; op < 16; op++) begin
        send(4'(op), sx[s], sy[s], 32'h0000_0100, w);
      end
    end
    settle();
    chk("no_bundle_lost", 32'(exp_q.size()), 32'd0);
    chk("acc_eq_del", 32'(acc_cnt), 32'(del_cnt));

    // Reset in the middle of a multiply
    out_ready = 1'b0;
    send(4'h3, 32'd6, 32'd7, 32'd1, w);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mul_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_rhs", out_rhs, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rel_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
